conv_engine: RTL and testbench
==============================

CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  in  1  one-cycle request to convolve the stored 4x4 input with the stored 3x3 filter.
REQ-004 SHALL have ports: in_A0/in_A1/in_A2  in  8 each  input-matrix read data for addr_A0..2.
REQ-005 SHALL have ports: in_F0/in_F1/in_F2  in  8 each  filter read data for addr_F0..2.
REQ-006 SHALL have ports: addr_A0/addr_A1/addr_A2  out  4 each  input-matrix read addresses.
REQ-007 SHALL have ports: addr_F0/addr_F1/addr_F2  out  4 each  filter read addresses.
REQ-008 SHALL have ports: en_INP, en_FIL  out  2 each  memory enables; 2'b10 = read, 2'b00 = idle.
REQ-009 SHALL have ports: data_w  out  8  result byte; addr_S0  out  2  serial output slot; en_S  out  2  2'b11 = write.
REQ-010 SHALL have ports: busy  out  1  high from accepted start until done; done  out  1  one-cycle completion pulse.

Function
REQ-011 SHALL compute a valid (no padding) 2x2 output: O(r,c) = sum over k,j in 0..2 of A[(r+k)*4+c+j] * F[k*3+j], all unsigned.
REQ-012 SHALL process pixels in order (0,0),(0,1),(1,0),(1,1); addr_S0 = r*2+c.
REQ-013 SHALL use FSM states IDLE, READ, DRAIN, WRITE, DONE.
REQ-014 IDLE -> READ on start; start while busy SHALL be ignored.
REQ-015 READ SHALL last 3 cycles (window row k = 0,1,2): addr_A_j = (r+k)*4+c+j, addr_F_j = k*3+j, en_INP = en_FIL = 2'b10.
REQ-016 Read data SHALL be sampled the cycle after its address (one-cycle memory read latency); rows accumulate at READ cycles 2,3 and DRAIN.
REQ-017 Per row, three 8x8 products SHALL be summed and added into a 20-bit accumulator cleared at the first READ cycle of each pixel.
REQ-018 WRITE SHALL last 1 cycle: en_S = 2'b11, addr_S0, data_w = reduced result (REQ-026); en_INP/en_FIL = 2'b00.
REQ-019 After WRITE, the next pixel SHALL enter READ; after pixel (1,1), DONE.
REQ-020 DONE SHALL last 1 cycle with done = 1, then IDLE; start in DONE is ignored.
REQ-021 Latency: 5 cycles per pixel; first write 5 cycles after start acceptance; done 21 cycles after acceptance.
REQ-022 Outside READ/WRITE, en_INP, en_FIL, en_S SHALL be 2'b00; addresses hold last value.

Reset
REQ-023 On rst low, SHALL immediately enter IDLE, clear accumulator and pixel counter; busy = done = 0, en_* = 2'b00, addr_* = 0, data_w = 0.
REQ-024 Reset mid-operation SHALL abort without any further memory write; next start restarts at pixel (0,0).

Configuration
REQ-025 Macro CONV_ENGINE_SAT_EN SHALL select output reduction.
REQ-026 With CONV_ENGINE_SAT_EN defined, data_w = min(acc, 255); without it, data_w = acc[7:0] (truncation).

Structure
REQ-027 Package conv_pkg SHALL hold the FSM state enum, IMG_DIM = 4, K_DIM = 3, OUT_DIM = 2, DATA_W = 8, ACC_W = 20.
REQ-028 A combinational sub-module conv_mac3 (three 8x8 products summed, 18-bit result) SHALL be instantiated once.

Verification
REQ-029 A[i] = i, F = 1..9, SAT_EN defined, start -> writes slot0..3 = 255,255,255,255 (raw 303,348,...).
REQ-030 Same data, SAT_EN undefined -> slot0 = 47 (303 mod 256), slot1 = 92 (348 mod 256).
REQ-031 A[i] = i, F all 0 except F[4] = 1 -> slots 0..3 = 5,6,9,10; done exactly 21 cycles after start.
REQ-032 Second start pulse during busy -> ignored; exactly 4 en_S writes, one done pulse.
REQ-033 rst low during second pixel READ -> all enables 2'b00 immediately, no write; new start -> full 4-write sequence from slot 0.
REQ-034 A all 255, F all 255, SAT_EN undefined -> accumulator 585225 without overflow; data_w = 585225 mod 256 = 9.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and dimensions for the 4x4 * 3x3 valid convolution engine.
package conv_pkg;

  localparam int IMG_DIM = 4;
  localparam int K_DIM   = 3;
  localparam int OUT_DIM = 2;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 20;
  localparam int MAC_W   = 18;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Input address of window tap (k, j) for output pixel pix = {r, c}: (r+k)*4 + c + j.
  function automatic logic [3:0] img_addr(input logic [1:0] pix, input logic [1:0] k,
                                          input logic [1:0] j);
    logic [3:0] row;
    row = {3'b000, pix[1]} + {2'b00, k};
    return (row << 2) + {3'b000, pix[0]} + {2'b00, j};
  endfunction

  function automatic logic [3:0] filt_addr(input logic [1:0] k, input logic [1:0] j);
    return ({2'b00, k} * 4'd3) + {2'b00, j};
  endfunction

endpackage

// File: rtl/conv_mac3.sv
// Combinational three-tap multiply-add: one filter row against one image row.
module conv_mac3
  import conv_pkg::*;
(
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] a2,
  input  logic [DATA_W-1:0] f0,
  input  logic [DATA_W-1:0] f1,
  input  logic [DATA_W-1:0] f2,
  output logic [MAC_W-1:0]  sum
);

  logic [15:0] p0_s;
  logic [15:0] p1_s;
  logic [15:0] p2_s;

  // Three full-width products, summed with two bits of headroom (3 * 255 * 255 < 2^18).
  always_comb begin
    p0_s = a0 * f0;
    p1_s = a1 * f1;
    p2_s = a2 * f2;
    sum  = {2'b00, p0_s} + {2'b00, p1_s} + {2'b00, p2_s};
  end

endmodule

// File: rtl/conv_engine.sv
// 4x4 input * 3x3 filter valid convolution, one window row per read cycle.
// Define CONV_ENGINE_SAT_EN to saturate results at 255 instead of truncating.
module conv_engine
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_A0,
  input  logic [DATA_W-1:0] in_A1,
  input  logic [DATA_W-1:0] in_A2,
  input  logic [DATA_W-1:0] in_F0,
  input  logic [DATA_W-1:0] in_F1,
  input  logic [DATA_W-1:0] in_F2,
  output logic [3:0]        addr_A0,
  output logic [3:0]        addr_A1,
  output logic [3:0]        addr_A2,
  output logic [3:0]        addr_F0,
  output logic [3:0]        addr_F1,
  output logic [3:0]        addr_F2,
  output logic [1:0]        en_INP,
  output logic [1:0]        en_FIL,
  output logic [DATA_W-1:0] data_w,
  output logic [1:0]        addr_S0,
  output logic [1:0]        en_S,
  output logic              busy,
  output logic              done
);

  function automatic logic [DATA_W-1:0] reduce_acc(input logic [ACC_W-1:0] acc);
`ifdef CONV_ENGINE_SAT_EN
    return (acc > 20'd255) ? 8'hFF : DATA_W'(acc);
`else
    return DATA_W'(acc);
`endif
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        pix_q, pix_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [MAC_W-1:0]  mac_sum_s;

  logic [3:0]        addr_a_q [3];
  logic [3:0]        addr_a_d [3];
  logic [3:0]        addr_f_q [3];
  logic [3:0]        addr_f_d [3];
  logic [1:0]        en_inp_q, en_inp_d;
  logic [1:0]        en_fil_q, en_fil_d;
  logic [1:0]        en_s_q, en_s_d;
  logic [1:0]        addr_s_q, addr_s_d;
  logic [DATA_W-1:0] data_w_q, data_w_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  conv_mac3 u_mac (
    .a0  (in_A0),
    .a1  (in_A1),
    .a2  (in_A2),
    .f0  (in_F0),
    .f1  (in_F1),
    .f2  (in_F2),
    .sum (mac_sum_s)
  );

  // Sequencer: data returned during READ k=1,2 and DRAIN belongs to rows 0,1,2.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    pix_d   = pix_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          k_d     = 2'd0;
          pix_d   = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (k_q == 2'd0) begin
          acc_d = '0;
        end else begin
          acc_d = acc_q + {2'b00, mac_sum_s};
        end
        if (k_q == 2'd2) begin
          state_d = DRAIN;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      DRAIN: begin
        acc_d   = acc_q + {2'b00, mac_sum_s};
        state_d = WRITE;
      end
      WRITE: begin
        if (pix_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = READ;
          pix_d   = pix_q + 2'd1;
          k_d     = 2'd0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with the state they belong to.
  always_comb begin
    en_inp_d = (state_d == READ)  ? 2'b10 : 2'b00;
    en_fil_d = (state_d == READ)  ? 2'b10 : 2'b00;
    en_s_d   = (state_d == WRITE) ? 2'b11 : 2'b00;
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    addr_a_d = addr_a_q;
    addr_f_d = addr_f_q;
    addr_s_d = addr_s_q;
    data_w_d = data_w_q;
    if (state_d == READ) begin
      for (int j = 0; j < K_DIM; j++) begin
        addr_a_d[j] = img_addr(pix_d, k_d, 2'(j));
        addr_f_d[j] = filt_addr(k_d, 2'(j));
      end
    end else begin
      addr_a_d = addr_a_q;
      addr_f_d = addr_f_q;
    end
    if (state_d == WRITE) begin
      addr_s_d = pix_d;
      data_w_d = reduce_acc(acc_d);
    end else begin
      addr_s_d = addr_s_q;
      data_w_d = data_w_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      k_q      <= 2'd0;
      pix_q    <= 2'd0;
      acc_q    <= '0;
      addr_a_q <= '{4'd0, 4'd0, 4'd0};
      addr_f_q <= '{4'd0, 4'd0, 4'd0};
      en_inp_q <= 2'b00;
      en_fil_q <= 2'b00;
      en_s_q   <= 2'b00;
      addr_s_q <= 2'd0;
      data_w_q <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      pix_q    <= pix_d;
      acc_q    <= acc_d;
      addr_a_q <= addr_a_d;
      addr_f_q <= addr_f_d;
      en_inp_q <= en_inp_d;
      en_fil_q <= en_fil_d;
      en_s_q   <= en_s_d;
      addr_s_q <= addr_s_d;
      data_w_q <= data_w_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign addr_A0 = addr_a_q[0];
  assign addr_A1 = addr_a_q[1];
  assign addr_A2 = addr_a_q[2];
  assign addr_F0 = addr_f_q[0];
  assign addr_F1 = addr_f_q[1];
  assign addr_F2 = addr_f_q[2];
  assign en_INP  = en_inp_q;
  assign en_FIL  = en_fil_q;
  assign en_S    = en_s_q;
  assign addr_S0 = addr_s_q;
  assign data_w  = data_w_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_conv_engine.sv
// Directed bench for conv_engine with one-cycle-latency memory models and a write log.
module tb_conv_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_A0, in_A1, in_A2, in_F0, in_F1, in_F2;
  logic [3:0] addr_A0, addr_A1, addr_A2, addr_F0, addr_F1, addr_F2;
  logic [1:0] en_INP, en_FIL, en_S, addr_S0;
  logic [7:0] data_w;
  logic       busy, done;

  conv_engine dut (
    .clk(clk), .rst(rst), .start(start),
    .in_A0(in_A0), .in_A1(in_A1), .in_A2(in_A2),
    .in_F0(in_F0), .in_F1(in_F1), .in_F2(in_F2),
    .addr_A0(addr_A0), .addr_A1(addr_A1), .addr_A2(addr_A2),
    .addr_F0(addr_F0), .addr_F1(addr_F1), .addr_F2(addr_F2),
    .en_INP(en_INP), .en_FIL(en_FIL), .data_w(data_w),
    .addr_S0(addr_S0), .en_S(en_S), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem_a [16];
  logic [7:0] mem_f [16];

  // Synchronous-read memories: data appears the cycle after the address.
  always @(posedge clk) begin
    in_A0 <= mem_a[addr_A0];
    in_A1 <= mem_a[addr_A1];
    in_A2 <= mem_a[addr_A2];
    in_F0 <= mem_f[addr_F0];
    in_F1 <= mem_f[addr_F1];
    in_F2 <= mem_f[addr_F2];
  end

  int cyc = 0;
  int t0  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] wslot [$];
  logic [7:0] wdata [$];
  int         wrel  [$];
  int         done_cnt = 0;
  int         done_rel = 0;

  // Log every output write and done pulse with its cycle number relative to start acceptance.
  always @(negedge clk) begin
    if (en_S == 2'b11) begin
      wslot.push_back(addr_S0);
      wdata.push_back(data_w);
      wrel.push_back(cyc - t0 + 1);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_rel = cyc - t0 + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wslot.delete();
    wdata.delete();
    wrel.delete();
    done_cnt = 0;
    done_rel = 0;
  endtask

  // Pulse start for one cycle; returns #1 into the first cycle after acceptance.
  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
  endtask

  task automatic check_run(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_d [4];
    exp_d = '{e0, e1, e2, e3};
    check({tag, " nwrites"}, wslot.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wslot.size()) begin
        check($sformatf("%s slot%0d", tag, i), wslot[i], i);
        check($sformatf("%s data%0d", tag, i), wdata[i], exp_d[i]);
        check($sformatf("%s wcyc%0d", tag, i), wrel[i], 5 * (i + 1));
      end
    end
    check({tag, " done_cnt"}, done_cnt, 1);
    check({tag, " done_cyc"}, done_rel, 21);
    check({tag, " busy_end"}, busy, 0);
  endtask

  logic [7:0] exp_ramp [4];
  logic [7:0] exp_full;

  initial begin
`ifdef CONV_ENGINE_SAT_EN
    exp_ramp = '{8'd255, 8'd255, 8'd255, 8'd255};
    exp_full = 8'd255;
`else
    exp_ramp = '{8'd47, 8'd92, 8'd227, 8'd16};
    exp_full = 8'd9;
`endif
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'(i);
      mem_f[i] = (i < 9) ? 8'(i + 1) : 8'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst en_INP", en_INP, 0);
    check("rst en_FIL", en_FIL, 0);
    check("rst en_S", en_S, 0);
    check("rst addr_A2", addr_A2, 0);
    check("rst addr_F2", addr_F2, 0);
    check("rst data_w", data_w, 0);
    rst = 1'b1;

    // Ramp image, filter 1..9
    clear_log();
    do_start();
    check("ramp busy1", busy, 1);
    check("ramp en_INP1", en_INP, 2'b10);
    check("ramp en_FIL1", en_FIL, 2'b10);
    check("ramp addr_A2", addr_A2, 2);
    check("ramp addr_F2", addr_F2, 2);
    @(posedge clk);
    #1;
    check("ramp addr_A0 k1", addr_A0, 4);
    check("ramp addr_F0 k1", addr_F0, 3);
    repeat (29) @(posedge clk);
    #1;
    check_run("ramp", exp_ramp[0], exp_ramp[1], exp_ramp[2], exp_ramp[3]);

    // Center-tap filter, with extra start pulses while busy and during DONE
    for (int i = 0; i < 16; i++) mem_f[i] = (i == 4) ? 8'd1 : 8'd0;
    clear_log();
    do_start();
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("center in DONE", done, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_run("center", 8'd5, 8'd6, 8'd9, 8'd10);

    // Reset during the second pixel's READ aborts with no further writes
    clear_log();
    do_start();
    repeat (6) @(posedge clk);
    #1;
    check("abort pre en_INP", en_INP, 2'b10);
    rst = 1'b0;
    #1;
    check("abort en_INP", en_INP, 0);
    check("abort en_FIL", en_FIL, 0);
    check("abort en_S", en_S, 0);
    check("abort busy", busy, 0);
    check("abort addr_A0", addr_A0, 0);
    repeat (10) @(posedge clk);
    #1;
    check("abort nwrites", wslot.size(), 1);
    check("abort done_cnt", done_cnt, 0);
    rst = 1'b1;
    clear_log();
    do_start();
    repeat (29) @(posedge clk);
    #1;
    check_run("restart", 8'd5, 8'd6, 8'd9, 8'd10);

    // All-ones data: accumulator reaches 585225 without overflow
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'd255;
      mem_f[i] = 8'd255;
    end
    clear_log();
    do_start();
    repeat (29) @(posedge clk);
    #1;
    check_run("full", exp_full, exp_full, exp_full, exp_full);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
